// File: rtl/a_pkg.sv
// Shared types and constants for the byte-to-frame packer.
package a_pkg;

    localparam int FRAME_LEN = 8;

    typedef logic [7:0] byte_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } packer_state_t;

    // Saturating increment used by the drop counter.
    function automatic byte_t sat_inc(input byte_t v);
        byte_t r;
        if (v == 8'hFF) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/a_idle_timer.sv
// Idle-cycle timer: counts consecutive idle cycles while a frame is being
// filled and flags the cycle in which the TIMEOUT-th idle cycle ends.
// TIMEOUT = 0 disables expiry.
module a_idle_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic i_run,
    input  logic i_activity,
    output logic o_expire
);

    localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam bit            EN   = (TIMEOUT != 0);

    logic [CW-1:0] r_cnt;
    logic          w_expire;

    // Expiry is combinational so the drop happens on the edge that ends the
    // last allowed idle cycle; any byte in that cycle suppresses it.
    always_comb begin
        w_expire = 1'b0;
        if (EN && i_run && !i_activity && (r_cnt == LAST)) begin
            w_expire = 1'b1;
        end else begin
            w_expire = 1'b0;
        end
    end

    // Idle counter: restarts on activity, outside a frame, or on expiry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (!i_run || i_activity || w_expire) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_expire = w_expire;

endmodule

// File: rtl/a_frame_packer.sv
// Packs a valid-qualified serial byte stream into 8-byte parallel frames.
// Partial frames that are aborted by a new SOF or stall past TIMEOUT, and
// bytes arriving outside a frame, are discarded and counted.
module a_frame_packer
    import a_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    input  logic       in_sof,
    input  logic [7:0] in_data,
    output logic       valid,
    output logic [7:0] a,
    output logic [7:0] a1,
    output logic [7:0] a2,
    output logic [7:0] a3,
    output logic [7:0] a4,
    output logic [7:0] a5,
    output logic [7:0] a6,
    output logic [7:0] a7,
    output logic [7:0] drop_count,
    output logic       busy
);

    packer_state_t r_state;
    packer_state_t w_state_nxt;
    logic [2:0]    r_idx;
    logic [2:0]    w_idx_nxt;
    byte_t         r_cap [FRAME_LEN];
    byte_t         w_cap_nxt [FRAME_LEN];
    byte_t         r_out [FRAME_LEN];
    logic          r_valid;
    byte_t         r_drop;
    logic          w_cap_we;
    logic [2:0]    w_cap_pos;
    logic          w_done;
    logic          w_drop;
    logic          w_expire;

    a_idle_timer #(.TIMEOUT(TIMEOUT)) u_idle_timer (
        .clock      (clock),
        .reset      (reset),
        .i_run      (r_state == FILL),
        .i_activity (in_valid),
        .o_expire   (w_expire)
    );

    // Next-state logic: frame sequencing, drop detection and capture control.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cap_we    = 1'b0;
        w_cap_pos   = r_idx;
        w_done      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid && in_sof) begin
                    w_cap_we    = 1'b1;
                    w_cap_pos   = 3'd0;
                    w_idx_nxt   = 3'd1;
                    w_state_nxt = FILL;
                end else if (in_valid) begin
                    w_drop = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            FILL: begin
                if (in_valid && in_sof) begin
                    // Restart: old partial frame is discarded, new byte 0 kept.
                    w_drop    = 1'b1;
                    w_cap_we  = 1'b1;
                    w_cap_pos = 3'd0;
                    w_idx_nxt = 3'd1;
                end else if (in_valid) begin
                    w_cap_we = 1'b1;
                    if (r_idx == 3'd7) begin
                        w_done      = 1'b1;
                        w_idx_nxt   = 3'd0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end else if (w_expire) begin
                    w_drop      = 1'b1;
                    w_idx_nxt   = 3'd0;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = FILL;
                end
            end
            default: begin
                w_idx_nxt   = 3'd0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Capture array with the incoming byte merged in; also feeds the output
    // bank so byte 7 lands in the output on the same edge it is accepted.
    always_comb begin
        w_cap_nxt = r_cap;
        if (w_cap_we) begin
            w_cap_nxt[w_cap_pos] = in_data;
        end else begin
            w_cap_nxt = r_cap;
        end
    end

    // Control state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_idx   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Capture and output register banks plus valid pulse and drop counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                r_cap[i] <= 8'h00;
                r_out[i] <= 8'h00;
            end
            r_valid <= 1'b0;
            r_drop  <= 8'h00;
        end else begin
            r_cap   <= w_cap_nxt;
            r_valid <= w_done;
            if (w_done) begin
                r_out <= w_cap_nxt;
            end
            if (w_drop) begin
                r_drop <= sat_inc(r_drop);
            end
        end
    end

    assign valid      = r_valid;
    assign a          = r_out[0];
    assign a1         = r_out[1];
    assign a2         = r_out[2];
    assign a3         = r_out[3];
    assign a4         = r_out[4];
    assign a5         = r_out[5];
    assign a6         = r_out[6];
    assign a7         = r_out[7];
    assign drop_count = r_drop;
    assign busy       = (r_state == FILL);

endmodule

// File: tb/tb_a_frame_packer.sv
// Bench for a_frame_packer: directed test-plan scenarios with literal
// expectations, then randomized traffic, all against a frame-level model.
module tb_a_frame_packer;

    localparam int T = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       valid;
    logic [7:0] a, a1, a2, a3, a4, a5, a6, a7;
    logic [7:0] drop_count;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    a_frame_packer #(.TIMEOUT(T)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_data    (in_data),
        .valid      (valid),
        .a          (a),
        .a1         (a1),
        .a2         (a2),
        .a3         (a3),
        .a4         (a4),
        .a5         (a5),
        .a6         (a6),
        .a7         (a7),
        .drop_count (drop_count),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    logic [7:0] dut_a [8];
    assign dut_a[0] = a;
    assign dut_a[1] = a1;
    assign dut_a[2] = a2;
    assign dut_a[3] = a3;
    assign dut_a[4] = a4;
    assign dut_a[5] = a5;
    assign dut_a[6] = a6;
    assign dut_a[7] = a7;

    // Frame-level model: number of bytes held, their values, idle run length.
    int         m_cnt  = 0;
    int         m_idle = 0;
    int         m_drop = 0;
    logic       m_valid = 1'b0;
    logic [7:0] m_buf [8];
    logic [7:0] m_out [8];

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_cnt   <= 0;
            m_idle  <= 0;
            m_drop  <= 0;
            m_valid <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                m_buf[i] <= 8'h00;
                m_out[i] <= 8'h00;
            end
        end else begin
            int         cnt;
            int         idle;
            int         drp;
            logic       vld;
            logic [7:0] b [8];
            logic [7:0] o [8];
            cnt  = m_cnt;
            idle = m_idle;
            drp  = m_drop;
            vld  = 1'b0;
            b    = m_buf;
            o    = m_out;
            if (in_valid) begin
                idle = 0;
                if (in_sof) begin
                    if (cnt > 0) drp = (drp < 255) ? drp + 1 : drp;
                    b[0] = in_data;
                    cnt  = 1;
                end else if (cnt > 0) begin
                    b[cnt] = in_data;
                    cnt    = cnt + 1;
                    if (cnt == 8) begin
                        o   = b;
                        vld = 1'b1;
                        cnt = 0;
                    end
                end else begin
                    drp = (drp < 255) ? drp + 1 : drp;
                end
            end else if (cnt > 0) begin
                idle = idle + 1;
                if (T != 0 && idle == T) begin
                    drp  = (drp < 255) ? drp + 1 : drp;
                    cnt  = 0;
                    idle = 0;
                end
            end else begin
                idle = 0;
            end
            m_cnt   <= cnt;
            m_idle  <= idle;
            m_drop  <= drp;
            m_valid <= vld;
            m_buf   <= b;
            m_out   <= o;
        end
    end

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        chk1("valid", valid, m_valid);
        for (int i = 0; i < 8; i++) begin
            chk8($sformatf("a%0d", i), dut_a[i], m_out[i]);
        end
        chk8("drop_count", drop_count, 8'(m_drop));
        chk1("busy", busy, m_cnt > 0);
    end

    task automatic drive(input logic v, input logic s, input logic [7:0] d);
        in_valid = v;
        in_sof   = s;
        in_data  = d;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'($urandom));
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk1("rst_valid", valid, 1'b0);
        chk8("rst_a", a, 8'h00);
        chk8("rst_a7", a7, 8'h00);
        chk8("rst_drop", drop_count, 8'h00);
        chk1("rst_busy", busy, 1'b0);
        reset = 1'b1;
        idle(2);

        // Clean frame
        drive(1'b1, 1'b1, 8'h10);
        for (int i = 1; i < 8; i++) drive(1'b1, 1'b0, 8'(8'h10 + i));
        chk1("clean_valid", valid, 1'b1);
        chk8("clean_a", a, 8'h10);
        chk8("clean_a3", a3, 8'h13);
        chk8("clean_a7", a7, 8'h17);
        chk8("clean_drop", drop_count, 8'h00);
        idle(1);
        chk1("clean_pulse_end", valid, 1'b0);
        chk8("clean_hold_a", a, 8'h10);

        // Back-to-back frames
        for (int i = 0; i < 8; i++) drive(1'b1, i == 0, 8'(i));
        chk1("b2b1_valid", valid, 1'b1);
        chk8("b2b1_a", a, 8'h00);
        chk8("b2b1_a7", a7, 8'h07);
        for (int i = 0; i < 8; i++) drive(1'b1, i == 0, 8'(8'h80 + i));
        chk1("b2b2_valid", valid, 1'b1);
        chk8("b2b2_a", a, 8'h80);
        chk8("b2b2_a7", a7, 8'h87);
        idle(2);

        // Stray bytes and SOF restart
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'(8'h50 + i));
        chk8("stray_drop", drop_count, 8'h03);
        chk1("stray_busy", busy, 1'b0);
        drive(1'b1, 1'b1, 8'h60);
        for (int i = 1; i < 5; i++) drive(1'b1, 1'b0, 8'(8'h60 + i));
        for (int i = 0; i < 8; i++) drive(1'b1, i == 0, 8'(8'hA0 + i));
        chk8("restart_drop", drop_count, 8'h04);
        chk1("restart_valid", valid, 1'b1);
        chk8("restart_a", a, 8'hA0);
        chk8("restart_a7", a7, 8'hA7);
        idle(2);

        // Timeout fires after T idle cycles
        for (int i = 0; i < 5; i++) drive(1'b1, i == 0, 8'(8'hC0 + i));
        idle(T - 1);
        chk1("to_busy_before", busy, 1'b1);
        idle(1);
        chk1("to_busy_after", busy, 1'b0);
        chk8("to_drop", drop_count, 8'h05);
        chk1("to_valid", valid, 1'b0);
        // Byte arriving in the would-be expiry cycle wins
        for (int i = 0; i < 5; i++) drive(1'b1, i == 0, 8'(8'hB0 + i));
        idle(T - 1);
        for (int i = 5; i < 8; i++) drive(1'b1, 1'b0, 8'(8'hB0 + i));
        chk1("to_save_valid", valid, 1'b1);
        chk8("to_save_drop", drop_count, 8'h05);
        chk8("to_save_a4", a4, 8'hB4);
        chk8("to_save_a5", a5, 8'hB5);
        idle(2);

        // Asynchronous reset mid-frame
        for (int i = 0; i < 6; i++) drive(1'b1, i == 0, 8'(8'hD0 + i));
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk1("arst_busy", busy, 1'b0);
        chk8("arst_a", a, 8'h00);
        chk8("arst_drop", drop_count, 8'h00);
        #3;
        reset = 1'b1;
        @(posedge clock);
        #1;
        idle(10);
        chk1("arst_no_valid", valid, 1'b0);
        chk8("arst_drop_after", drop_count, 8'h00);

        // Randomized traffic with bursts and idle gaps
        for (int r = 0; r < 300; r++) begin
            int gap;
            int len;
            gap = $urandom_range(0, 20);
            len = $urandom_range(1, 12);
            idle(gap);
            for (int i = 0; i < len; i++) begin
                logic s;
                s = (i == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 7) == 0) drive(1'b0, 1'b0, 8'($urandom));
                else drive(1'b1, s, 8'($urandom));
            end
        end

        // Drop counter saturation
        idle(T + 2);
        for (int i = 0; i < 300; i++) drive(1'b1, 1'b0, 8'(i));
        chk8("sat_drop", drop_count, 8'hFF);
        chk1("sat_busy", busy, 1'b0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
